// File: rtl/prco_loader_pkg.sv
// prco_loader_pkg: shared types and constants for the lmem program loader.
package prco_loader_pkg;
  localparam int WORD_W = 16;
  localparam logic [WORD_W-1:0] MAGIC_DEFAULT = 16'h5052;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_CKSUM = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;
endpackage

// File: rtl/prco_loader_cksum.sv
// prco_loader_cksum: 16-bit modular accumulator over the payload words of a frame.
module prco_loader_cksum
  import prco_loader_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_clr,
  input  logic              i_add,
  input  logic [WORD_W-1:0] i_data,
  output logic [WORD_W-1:0] q_sum
);
  // Clear at the start of a frame, then add each accepted payload word (wraps mod 2^16).
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) q_sum <= '0;
    else if (i_clr) q_sum <= '0;
    else if (i_add) q_sum <= q_sum + i_data;
endmodule

// File: rtl/prco_lmem_loader.sv
// prco_lmem_loader: framed word stream -> lmem writes, holding the core in reset while loading.
// Define PRCO_LOADER_CKSUM_EN to require a trailing checksum word on every frame.
module prco_lmem_loader
  import prco_loader_pkg::*;
#(
  parameter int                ADDR_W    = 8,
  parameter logic [WORD_W-1:0] BASE_ADDR = 16'h0000,
  parameter logic [WORD_W-1:0] MAGIC     = MAGIC_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_en,
  input  logic              i_p_valid,
  input  logic [WORD_W-1:0] i_p_data,
  output logic              q_p_stalled,
  output logic              q_mem_we,
  output logic [WORD_W-1:0] q_mem_addr,
  output logic [WORD_W-1:0] q_mem_dina,
  output logic              q_core_reset,
  output logic              q_done,
  output logic              q_err
);
  localparam logic [WORD_W:0] CAP = (WORD_W + 1)'(1) << ADDR_W;
  state_t            state;
  logic [WORD_W-1:0] cnt;
  logic [ADDR_W-1:0] addr;
  logic              acc, is_magic, bad_len, last;
  assign q_p_stalled = !i_en;
  assign acc         = i_p_valid && i_en;
  assign is_magic    = i_p_data == MAGIC;
  assign bad_len     = i_p_data == '0 || {1'b0, i_p_data} > CAP;
  assign last        = cnt == WORD_W'(1);
`ifdef PRCO_LOADER_CKSUM_EN
  logic [WORD_W-1:0] sum;
  prco_loader_cksum u_cksum (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_clr  (state == S_LEN && acc && !bad_len),
    .i_add  (state == S_DATA && acc),
    .i_data (i_p_data),
    .q_sum  (sum)
  );
`endif
  // Frame parser: all decisions on accepted words; everything freezes while i_en is low.
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      addr         <= '0;
      q_mem_we     <= 1'b0;
      q_mem_addr   <= '0;
      q_mem_dina   <= '0;
      q_core_reset <= 1'b0;
      q_done       <= 1'b0;
      q_err        <= 1'b0;
    end else if (!i_en) begin
      q_mem_we <= 1'b0;
      q_done   <= 1'b0;
    end else begin
      q_mem_we <= 1'b0;
      q_done   <= 1'b0;
      case (state)
        S_IDLE, S_ERR: if (acc && is_magic) begin
          state        <= S_LEN;
          q_core_reset <= 1'b1;
          q_err        <= 1'b0;
        end
        S_LEN: if (acc) begin
          if (bad_len) begin
            state <= S_ERR;
            q_err <= 1'b1;
          end else begin
            state <= S_DATA;
            cnt   <= i_p_data;
            addr  <= BASE_ADDR[ADDR_W-1:0];
          end
        end
        S_DATA: if (acc) begin
          q_mem_we   <= 1'b1;
          q_mem_addr <= WORD_W'(addr);
          q_mem_dina <= i_p_data;
          addr       <= addr + ADDR_W'(1);
          cnt        <= cnt - WORD_W'(1);
`ifdef PRCO_LOADER_CKSUM_EN
          if (last) state <= S_CKSUM;
`else
          if (last) begin
            state        <= S_DONE;
            q_done       <= 1'b1;
            q_core_reset <= 1'b0;
          end
`endif
        end
`ifdef PRCO_LOADER_CKSUM_EN
        S_CKSUM: if (acc) begin
          if (i_p_data == sum) begin
            state        <= S_DONE;
            q_done       <= 1'b1;
            q_core_reset <= 1'b0;
          end else begin
            state <= S_ERR;
            q_err <= 1'b1;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
endmodule
